mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//   MEM stage plus MEM/WB latch. Sits directly downstream of the EX/MEM latch.
//   Runs loads/stores on a data-memory bus with a req/ready handshake.
//   Stalls the upstream pipeline while a memory access is outstanding.
//   Registers the writeback bundle (ALU result, load data, JAL link, ctrl).
// PARAMETERS
//   DATA_WIDTH      32  data, address and PC width
//   REG_ADDR_WIDTH  5   destination register index width
//   TIMEOUT_CYCLES  16  WAIT-cycle limit before abort (only with MEM_TIMEOUT_EN)
// PORTS
//   clk                 in   1   single clock, rising edge
//   reset               in   1   asynchronous, active-low (0 = reset asserted)
//   flush               in   1   kill the instruction currently in MEM
//   alu_result_in       in   32  effective address / ALU result
//   read_data_2_in      in   32  store data (rt)
//   write_register_in   in   5   destination register
//   reg_write_in        in   1   register-write enable
//   mem_read_in         in   1   load
//   mem_write_in        in   1   store
//   mem_to_reg_in       in   1   1 = WB takes memory data
//   pc_plus_4_in        in   32  link value for JAL/JALR
//   is_jal_in           in   1   JAL/JALR marker
//   dmem_req            out  1   bus request
//   dmem_we             out  1   1 = write
//   dmem_addr           out  32  word address {addr[31:2],2'b00}
//   dmem_wdata          out  32  store data
//   dmem_ready          in   1   bus done; dmem_rdata valid in the same cycle
//   dmem_rdata          in   32  load data
//   stall_out           out  1   hold PC, IF/ID, ID/EX and EX/MEM
//   bus_error           out  1   one-cycle pulse on access timeout
//   wb_alu_result       out  32  registered ALU result
//   wb_mem_data         out  32  registered load data
//   wb_write_register   out  5   registered destination register
//   wb_reg_write        out  1   registered register-write enable
//   wb_mem_to_reg       out  1   registered writeback mux select
//   wb_pc_plus_4        out  32  registered link value
//   wb_is_jal           out  1   registered JAL marker
// BEHAVIOUR
//   Reset: state IDLE. All registered outputs, dmem_* and bus_error are 0.
//     Async assert; removal takes effect synchronously on the next clk edge.
//   IDLE, no access (mem_read_in = mem_write_in = 0):
//     inputs pass to wb_* on the next edge; latency 1; stall_out = 0; wb_mem_data <= 0.
//   IDLE, access and !flush:
//     stall_out = 1 combinationally.
//     Latch address, wdata, we and the ctrl bundle; go to WAIT.
//     dmem_req = 1 from the next cycle; wb_reg_write <= 0 (bubble).
//   WAIT: dmem_req/we/addr/wdata held stable until dmem_ready = 1.
//     stall_out = !dmem_ready.
//     On ready: wb_* <= latched bundle, wb_mem_data <= dmem_rdata (loads only).
//       dmem_req <= 0; go to IDLE.
//     Stores: wb_reg_write <= latched reg_write (0 for well-formed stores).
//     Min load latency = 2 edges from entry.
//     Upstream advances in the ready cycle, since stall_out drops combinationally.
//   Read and write both set: write wins, no read is performed.
//   flush in IDLE: no access started; wb_reg_write <= 0; stall_out = 0.
//   flush in WAIT: the bus transaction still completes (no mid-transfer abort).
//     The result is discarded (wb_reg_write <= 0).
//     A flush-pending flag holds until ready; stall stays asserted per the WAIT rule.
//   Every bubble also forces wb_mem_to_reg and wb_is_jal to 0.
//   Reset mid-WAIT: dmem_req drops immediately. No completion is reported.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined:
//     An 8-bit counter clears on WAIT entry and increments each WAIT cycle without ready.
//     When it reaches TIMEOUT_CYCLES:
//       dmem_req <= 0, bubble to WB, bus_error pulses 1 cycle, go to IDLE.
//       stall_out drops in that cycle.
//   MEM_TIMEOUT_EN undefined: WAIT is unbounded; bus_error is tied to 0; no counter.
// TESTING
//   Reset low mid-WAIT -> dmem_req, stall_out, all wb_* = 0 within the same cycle.
//   ALU op r5 = 0x1234 (no mem) -> next edge: wb_reg_write = 1, wb_alu_result = 0x1234, stall_out = 0.
//   Load @0x100, dmem_ready after 3 WAIT cycles, rdata 0xCAFEF00D:
//     -> stall_out high 4 cycles; dmem_addr = 0x100 held.
//     -> then wb_mem_data = 0xCAFEF00D, wb_mem_to_reg = 1.
//   Store 0xDEADBEEF @0x203 -> dmem_we = 1, dmem_addr = 0x200, dmem_wdata = 0xDEADBEEF; wb_reg_write = 0.
//   Flush during WAIT of a load -> req held until ready; then wb_reg_write = 0 and stall_out released.
//   MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 16, ready never high:
//     -> bus_error pulse 16 cycles after req, dmem_req = 0, IDLE.
//     -> Without the macro, stall_out stays high indefinitely.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage and MEM/WB latch.
// Issues loads/stores over a req/ready data-memory bus, stalls the upstream
// pipeline while an access is outstanding and registers the writeback bundle.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without ready (pulses bus_error).
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     read_data_2_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic                      reg_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      mem_to_reg_in,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_in,
  input  logic                      is_jal_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ready,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      stall_out,
  output logic                      bus_error,
  output logic [DATA_WIDTH-1:0]     wb_alu_result,
  output logic [DATA_WIDTH-1:0]     wb_mem_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_register,
  output logic                      wb_reg_write,
  output logic                      wb_mem_to_reg,
  output logic [DATA_WIDTH-1:0]     wb_pc_plus_4,
  output logic                      wb_is_jal
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state;
  logic                      access;
  logic                      start;
  logic                      timeout_hit;
  logic                      flush_pending;

  // Instruction held in MEM while the bus access is outstanding
  logic [DATA_WIDTH-1:0]     alu_result_p0;
  logic [REG_ADDR_WIDTH-1:0] write_register_p0;
  logic [DATA_WIDTH-1:0]     pc_plus_4_p0;
  logic                      reg_write_p0;
  logic                      mem_to_reg_p0;
  logic                      is_jal_p0;
  logic                      is_load_p0;

  // Bus addresses are word aligned; the byte offset is dropped
  function automatic logic [DATA_WIDTH-1:0] word_addr(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

  assign access = mem_read_in | mem_write_in;
  assign start  = (state == S_IDLE) && access && !flush;

  // Stall while entering an access and for every WAIT cycle that does not
  // complete; gated by reset so the pipeline is released immediately.
  assign stall_out = reset &&
                     (start || ((state == S_WAIT) && !dmem_ready && !timeout_hit));

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The counter reads TIMEOUT_CYCLES-1 in the last tolerated WAIT cycle;
  // the abort takes effect at the edge that ends it.
  assign timeout_hit = (state == S_WAIT) && !dmem_ready &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles without ready and pulse bus_error on abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= timeout_hit;
      if (start)
        wait_cnt <= '0;
      else if ((state == S_WAIT) && !dmem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // Latch the data side of the instruction when its access is started
  always_ff @(posedge clk) begin
    if (start) begin
      alu_result_p0     <= alu_result_in;
      write_register_p0 <= write_register_in;
      pc_plus_4_p0      <= pc_plus_4_in;
    end
  end

  // Stage FSM: bus handshake, control latch and MEM/WB register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      flush_pending     <= 1'b0;
      reg_write_p0      <= 1'b0;
      mem_to_reg_p0     <= 1'b0;
      is_jal_p0         <= 1'b0;
      is_load_p0        <= 1'b0;
      wb_alu_result     <= '0;
      wb_mem_data       <= '0;
      wb_write_register <= '0;
      wb_reg_write      <= 1'b0;
      wb_mem_to_reg     <= 1'b0;
      wb_pc_plus_4      <= '0;
      wb_is_jal         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wb_alu_result     <= alu_result_in;
          wb_write_register <= write_register_in;
          wb_pc_plus_4      <= pc_plus_4_in;
          wb_mem_data       <= '0;
          if (start) begin
            state         <= S_WAIT;
            dmem_req      <= 1'b1;
            dmem_we       <= mem_write_in;
            dmem_addr     <= word_addr(alu_result_in);
            dmem_wdata    <= read_data_2_in;
            flush_pending <= 1'b0;
            reg_write_p0  <= reg_write_in;
            mem_to_reg_p0 <= mem_to_reg_in;
            is_jal_p0     <= is_jal_in;
            // write wins when both are set: no read data is returned
            is_load_p0    <= mem_read_in && !mem_write_in;
          end
          if (start || flush) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_is_jal     <= 1'b0;
          end else begin
            wb_reg_write  <= reg_write_in;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_is_jal     <= is_jal_in;
          end
        end
        S_WAIT: begin
          if (flush)
            flush_pending <= 1'b1;
          if (dmem_ready) begin
            state             <= S_IDLE;
            dmem_req          <= 1'b0;
            flush_pending     <= 1'b0;
            wb_alu_result     <= alu_result_p0;
            wb_write_register <= write_register_p0;
            wb_pc_plus_4      <= pc_plus_4_p0;
            wb_mem_data       <= is_load_p0 ? dmem_rdata : '0;
            // a flushed access still completes on the bus but writes nothing back
            if (flush || flush_pending) begin
              wb_reg_write  <= 1'b0;
              wb_mem_to_reg <= 1'b0;
              wb_is_jal     <= 1'b0;
            end else begin
              wb_reg_write  <= reg_write_p0;
              wb_mem_to_reg <= mem_to_reg_p0;
              wb_is_jal     <= is_jal_p0;
            end
          end else begin
            if (timeout_hit) begin
              state         <= S_IDLE;
              dmem_req      <= 1'b0;
              flush_pending <= 1'b0;
            end
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_is_jal     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: scoreboard of expected writeback bundles,
// one task per scenario. Define MEM_TIMEOUT_EN to exercise the abort path.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] alu_result_in, read_data_2_in, pc_plus_4_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, is_jal_in;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_out, bus_error;
  logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus_4;
  logic [4:0]  wb_write_register;
  logic        wb_reg_write, wb_mem_to_reg, wb_is_jal;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic [31:0] pc4;
    logic        jal;
  } wb_t;

  wb_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_result_in(alu_result_in), .read_data_2_in(read_data_2_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .pc_plus_4_in(pc_plus_4_in),
    .is_jal_in(is_jal_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .bus_error(bus_error),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_write_register(wb_write_register), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_pc_plus_4(wb_pc_plus_4),
    .wb_is_jal(wb_is_jal)
  );

  always #5 clk = ~clk;

  function automatic wb_t observed();
    return '{alu: wb_alu_result, mem: wb_mem_data, wr: wb_write_register,
             rw: wb_reg_write, m2r: wb_mem_to_reg, pc4: wb_pc_plus_4, jal: wb_is_jal};
  endfunction

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [4:0] wr, input logic rw, input logic mr,
                          input logic mw, input logic m2r, input logic [31:0] pc4,
                          input logic jal);
    alu_result_in = alu; read_data_2_in = rd2; write_register_in = wr;
    reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
    mem_to_reg_in = m2r; pc_plus_4_in = pc4; is_jal_in = jal;
  endtask

  task automatic drive_idle();
    drive_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    wb_t got;
    reset = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    total++;
    if (got !== wb_t'(0)) $display("FAIL reset_wb: got %h want 0", got); else passed++;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, bus_error} !== 68'h0)
      $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h stall=%b err=%b want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, bus_error);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_alu_pass();
    wb_t e, got;
    drive_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0);
    exp_q.push_back('{alu: 32'h1234, mem: 32'h0, wr: 5'd5, rw: 1'b1, m2r: 1'b0,
                      pc4: 32'h40, jal: 1'b0});
    #1;
    total++;
    if (stall_out !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_out); else passed++;
    @(posedge clk); #1;
    e = exp_q.pop_front(); got = observed();
    total++;
    if (got !== e) $display("FAIL alu_wb: got %h want %h", got, e); else passed++;
    // JAL link passes through the same path
    drive_op(32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 32'h88, 1'b1);
    exp_q.push_back('{alu: 32'h0, mem: 32'h0, wr: 5'd31, rw: 1'b1, m2r: 1'b0,
                      pc4: 32'h88, jal: 1'b1});
    @(posedge clk); #1;
    e = exp_q.pop_front(); got = observed();
    total++;
    if (got !== e) $display("FAIL jal_wb: got %h want %h", got, e); else passed++;
  endtask

  task automatic test_back_to_back();
    wb_t e, got;
    int  errs = 0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, p;
      logic [4:0]  r;
      logic        rw, m2r, j;
      a = $urandom; p = $urandom; r = 5'($urandom);
      rw = 1'($urandom); m2r = 1'($urandom); j = 1'($urandom);
      drive_op(a, $urandom, r, rw, 1'b0, 1'b0, m2r, p, j);
      exp_q.push_back('{alu: a, mem: 32'h0, wr: r, rw: rw, m2r: m2r, pc4: p, jal: j});
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = observed();
      if (got !== e) begin
        errs++;
        $display("FAIL b2b_wb[%0d]: got %h want %h", i, got, e);
      end
    end
    total++;
    if (errs != 0) $display("FAIL b2b_summary: %0d of 6 wrong, want 0", errs); else passed++;
  endtask

  task automatic test_load();
    wb_t e, got;
    int  stall_cycles = 0;
    logic hold_ok = 1'b1;
    drive_op(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 1'b0);
    exp_q.push_back('{alu: 32'h100, mem: 32'hCAFEF00D, wr: 5'd7, rw: 1'b1, m2r: 1'b1,
                      pc4: 32'h50, jal: 1'b0});
    #1;
    if (stall_out === 1'b1) stall_cycles++;
    @(posedge clk); #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, wb_reg_write} !== {1'b1, 1'b0, 32'h100, 1'b0})
      $display("FAIL load_issue: req=%b we=%b addr=%h wb_rw=%b want 1 0 00000100 0",
               dmem_req, dmem_we, dmem_addr, wb_reg_write);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      if (stall_out === 1'b1) stall_cycles++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || wb_reg_write !== 1'b0) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
    drive_idle();
    #1;
    total++;
    if (stall_out !== 1'b0) $display("FAIL load_ready_stall: got %b want 0", stall_out); else passed++;
    total++;
    if (!hold_ok || dmem_addr !== 32'h100) $display("FAIL load_hold: addr=%h want 00000100 held", dmem_addr);
    else passed++;
    @(posedge clk); #1;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    e = exp_q.pop_front(); got = observed();
    total++;
    if (got !== e) $display("FAIL load_wb: got %h want %h", got, e); else passed++;
    total++;
    if (stall_cycles != 4 || dmem_req !== 1'b0)
      $display("FAIL load_stall_cycles: got %0d req=%b want 4 req=0", stall_cycles, dmem_req);
    else passed++;
  endtask

  task automatic test_store();
    wb_t e, got;
    drive_op(32'h203, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 1'b0);
    exp_q.push_back('{alu: 32'h203, mem: 32'h0, wr: 5'd3, rw: 1'b0, m2r: 1'b0,
                      pc4: 32'h60, jal: 1'b0});
    @(posedge clk); #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 32'hDEADBEEF})
      $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h want 1 1 00000200 deadbeef",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    else passed++;
    dmem_ready = 1'b1; dmem_rdata = 32'h5555AAAA;
    drive_idle();
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    e = exp_q.pop_front(); got = observed();
    total++;
    if (got !== e) $display("FAIL store_wb: got %h want %h", got, e); else passed++;
    // read and write both set: store happens, no load data returned
    drive_op(32'h301, 32'h13572468, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h64, 1'b0);
    exp_q.push_back('{alu: 32'h301, mem: 32'h0, wr: 5'd4, rw: 1'b0, m2r: 1'b0,
                      pc4: 32'h64, jal: 1'b0});
    @(posedge clk); #1;
    total++;
    if ({dmem_we, dmem_addr} !== {1'b1, 32'h300})
      $display("FAIL rw_both_bus: we=%b addr=%h want 1 00000300", dmem_we, dmem_addr);
    else passed++;
    dmem_ready = 1'b1; dmem_rdata = 32'h99998888;
    drive_idle();
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    e = exp_q.pop_front(); got = observed();
    total++;
    if (got !== e) $display("FAIL rw_both_wb: got %h want %h", got, e); else passed++;
  endtask

  task automatic test_flush_idle();
    drive_op(32'h77, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h70, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({wb_reg_write, wb_mem_to_reg, wb_is_jal, stall_out} !== 4'b0)
      $display("FAIL flush_idle_alu: rw=%b m2r=%b jal=%b stall=%b want 0 0 0 0",
               wb_reg_write, wb_mem_to_reg, wb_is_jal, stall_out);
    else passed++;
    drive_op(32'h400, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h74, 1'b0);
    flush = 1'b1;
    #1;
    total++;
    if (stall_out !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall_out); else passed++;
    @(posedge clk); #1;
    total++;
    if ({dmem_req, wb_reg_write} !== 2'b00)
      $display("FAIL flush_idle_load: req=%b rw=%b want 0 0", dmem_req, wb_reg_write);
    else passed++;
    drive_idle();
  endtask

  task automatic test_flush_wait();
    wb_t e;
    logic req_ok = 1'b1;
    drive_op(32'h104, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    exp_q.push_back('{alu: 32'h104, mem: 32'h11112222, wr: 5'd9, rw: 1'b0, m2r: 1'b0,
                      pc4: 32'h80, jal: 1'b0});
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) req_ok = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) req_ok = 1'b0;
    @(posedge clk); #1;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h104) req_ok = 1'b0;
    total++;
    if (!req_ok) $display("FAIL flush_wait_hold: req=%b stall=%b want req held and stall high",
                          dmem_req, stall_out);
    else passed++;
    dmem_ready = 1'b1; dmem_rdata = 32'h11112222;
    drive_idle();
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({wb_reg_write, wb_mem_to_reg, wb_is_jal, stall_out, dmem_req} !== {e.rw, e.m2r, e.jal, 2'b00})
      $display("FAIL flush_wait_wb: rw=%b m2r=%b jal=%b stall=%b req=%b want 0 0 0 0 0",
               wb_reg_write, wb_mem_to_reg, wb_is_jal, stall_out, dmem_req);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    wb_t got;
    drive_op(32'h180, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    got = observed();
    total++;
    if ({dmem_req, stall_out} !== 2'b00 || got !== wb_t'(0))
      $display("FAIL reset_mid_wait: req=%b stall=%b wb=%h want all 0", dmem_req, stall_out, got);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    dmem_ready = 1'b1; dmem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    total++;
    if ({wb_reg_write, wb_mem_data, dmem_req} !== 34'h0)
      $display("FAIL reset_no_completion: rw=%b mem=%h req=%b want 0", wb_reg_write, wb_mem_data, dmem_req);
    else passed++;
  endtask

  task automatic test_long_wait();
`ifdef MEM_TIMEOUT_EN
    int hit_edge = -1;
    drive_op(32'h500, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    for (int n = 1; n <= 40 && hit_edge < 0; n++) begin
      @(posedge clk); #1;
      if (bus_error === 1'b1) hit_edge = n;
    end
    total++;
    if (hit_edge != 16 || dmem_req !== 1'b0 || wb_reg_write !== 1'b0)
      $display("FAIL timeout: edge=%0d req=%b rw=%b want 16 0 0", hit_edge, dmem_req, wb_reg_write);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({bus_error, stall_out} !== 2'b00)
      $display("FAIL timeout_pulse: err=%b stall=%b want 0 0", bus_error, stall_out);
    else passed++;
`else
    int held = 0;
    drive_op(32'h500, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      if (stall_out === 1'b1 && dmem_req === 1'b1 && bus_error === 1'b0) held++;
      @(posedge clk); #1;
    end
    total++;
    if (held != 40) $display("FAIL no_timeout_stall: held %0d cycles want 40", held); else passed++;
    dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
    drive_idle();
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    total++;
    if ({wb_reg_write, wb_mem_data} !== {1'b1, 32'h0BADF00D})
      $display("FAIL long_wait_wb: rw=%b mem=%h want 1 0badf00d", wb_reg_write, wb_mem_data);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_back_to_back();
    test_load();
    test_store();
    test_flush_idle();
    test_flush_wait();
    test_reset_mid_wait();
    test_long_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
